// File: rtl/posit_decoder_pipe_pkg.sv
// Shared types for the posit decoder: sign and class enums plus the
// regime-width helper used to size the signed regime field.
package posit_decoder_pipe_pkg;

    typedef enum logic {
        POS = 1'b0,
        NEG = 1'b1
    } sign_t;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NAR    = 2'd1,
        NORMAL = 2'd2
    } posit_class_t;

    // A WIDTH-bit posit has |regime| <= WIDTH-1, which needs one sign bit on top.
    function automatic int posit_rw(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/posit_decoder_pipe_if.sv
// Stream interface for posit_decoder_pipe: raw posit in, decoded fields out.
// out_scale exists only when POSIT_DEC_SCALE_EN is defined.
interface posit_decoder_pipe_if #(
    parameter int WIDTH = 8,
    parameter int ES    = 1
);
    import posit_decoder_pipe_pkg::*;

    localparam int RW = posit_rw(WIDTH);
    localparam int EW = (ES > 1) ? ES : 1;
    localparam int MW = WIDTH - 3;
    localparam int LW = $clog2(WIDTH);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_posit;
    logic                 out_valid;
    logic                 out_ready;
    sign_t                out_sign;
    posit_class_t         out_class;
    logic signed [RW-1:0] out_regime;
    logic [EW-1:0]        out_exponent;
    logic [MW-1:0]        out_mantissa;
    logic [LW-1:0]        out_man_len;
`ifdef POSIT_DEC_SCALE_EN
    logic signed [RW+ES-1:0] out_scale;
`endif

    modport master (
        output in_valid, in_posit, out_ready,
        input  in_ready, out_valid, out_sign, out_class, out_regime,
               out_exponent, out_mantissa, out_man_len
`ifdef POSIT_DEC_SCALE_EN
        , input out_scale
`endif
    );

    modport slave (
        input  in_valid, in_posit, out_ready,
        output in_ready, out_valid, out_sign, out_class, out_regime,
               out_exponent, out_mantissa, out_man_len
`ifdef POSIT_DEC_SCALE_EN
        , output out_scale
`endif
    );

endinterface

// File: rtl/posit_decoder_pipe_run_length.sv
// posit_run_length: length of the run of bits equal to the MSB, counted
// from the MSB downward across all N bits (result 1..N).
module posit_run_length #(
    parameter int N = 7
) (
    input  logic [N-1:0]             vec,
    output logic [$clog2(N+1)-1:0]   len
);
    localparam int CW = $clog2(N + 1);

    logic run;

    always_comb begin
        len = CW'(1);
        run = 1'b1;
        for (int i = N - 2; i >= 0; i--) begin
            if (run && (vec[i] == vec[N-1])) begin
                len = len + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/posit_decoder_pipe.sv
// Two-stage posit field decoder: S1 classifies and takes |x|, S2 splits
// regime/exponent/fraction. Optional out_scale under POSIT_DEC_SCALE_EN.
module posit_decoder_pipe
    import posit_decoder_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ES    = 1
) (
    input logic                 clk,
    input logic                 rst,
    posit_decoder_pipe_if.slave bus
);
    localparam int RW = posit_rw(WIDTH);
    localparam int EW = (ES > 1) ? ES : 1;
    localparam int MW = WIDTH - 3;
    localparam int LW = $clog2(WIDTH);
    localparam int N  = WIDTH - 1;
    localparam logic [LW:0] ES_V = (LW + 1)'(ES);

    // Handshake: a beat moves when valid && ready. Each stage may load when it
    // is empty or its content leaves this cycle, so ready never looks at valid.
    logic s1_valid, s2_valid, s2_ready;
    assign s2_ready     = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_ready;
    assign bus.out_valid = s2_valid;

    // ---------------- S1: sign, class, magnitude ----------------
    posit_class_t in_class;
    logic [N-1:0] in_body;
    sign_t        s1_sign;
    posit_class_t s1_class;
    logic [N-1:0] s1_body;

    always_comb begin
        in_class = NORMAL;
        if (bus.in_posit == '0) begin
            in_class = ZERO;
        end else if (bus.in_posit == {1'b1, {N{1'b0}}}) begin
            in_class = NAR;
        end
        // Low bits of the two's complement depend only on the low bits.
        in_body = bus.in_posit[WIDTH-1] ? (~bus.in_posit[N-1:0] + N'(1))
                                        : bus.in_posit[N-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= POS;
            s1_class <= ZERO;
            s1_body  <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign  <= sign_t'(bus.in_posit[WIDTH-1]);
                s1_class <= in_class;
                s1_body  <= in_body;
            end
        end
    end

    // ---------------- S2: regime / exponent / fraction ----------------
    logic [LW-1:0]        run_len;
    logic [N-1:0]         tail;
    logic [LW:0]          rem;
    logic signed [RW-1:0] regime_d;
    logic [EW-1:0]        exp_d;
    logic [MW-1:0]        mant_d;
    logic [LW-1:0]        man_len_d;

    posit_run_length #(.N(N)) u_run_length (
        .vec (s1_body),
        .len (run_len)
    );

    always_comb begin
        regime_d  = '0;
        exp_d     = '0;
        mant_d    = '0;
        man_len_d = '0;
        // Bits after the terminator, MSB-aligned and zero-filled below.
        tail = (s1_body << run_len) << 1;
        rem  = (run_len == LW'(N)) ? '0 : (LW + 1)'(WIDTH - 2) - {1'b0, run_len};
        if (s1_class == NORMAL) begin
            regime_d  = s1_body[N-1] ? RW'(run_len) - RW'(1) : RW'(0) - RW'(run_len);
            exp_d     = (ES == 0) ? '0 : EW'({tail, {EW{1'b0}}} >> N);
            mant_d    = MW'((tail << ES) >> 2);
            man_len_d = (rem > ES_V) ? LW'(rem - ES_V) : '0;
        end
    end

`ifdef POSIT_DEC_SCALE_EN
    localparam int SW = RW + ES;
    logic signed [SW-1:0] scale_d;
    logic signed [SW-1:0] s2_scale;
    assign scale_d = (SW'(regime_d) <<< ES) + SW'(exp_d);
    assign bus.out_scale = s2_scale;
`endif

    sign_t                s2_sign;
    posit_class_t         s2_class;
    logic signed [RW-1:0] s2_regime;
    logic [EW-1:0]        s2_exponent;
    logic [MW-1:0]        s2_mantissa;
    logic [LW-1:0]        s2_man_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            s2_sign     <= POS;
            s2_class    <= ZERO;
            s2_regime   <= '0;
            s2_exponent <= '0;
            s2_mantissa <= '0;
            s2_man_len  <= '0;
`ifdef POSIT_DEC_SCALE_EN
            s2_scale    <= '0;
`endif
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign     <= s1_sign;
                s2_class    <= s1_class;
                s2_regime   <= regime_d;
                s2_exponent <= exp_d;
                s2_mantissa <= mant_d;
                s2_man_len  <= man_len_d;
`ifdef POSIT_DEC_SCALE_EN
                s2_scale    <= scale_d;
`endif
            end
        end
    end

    assign bus.out_sign     = s2_sign;
    assign bus.out_class    = s2_class;
    assign bus.out_regime   = s2_regime;
    assign bus.out_exponent = s2_exponent;
    assign bus.out_mantissa = s2_mantissa;
    assign bus.out_man_len  = s2_man_len;

endmodule

// File: tb/tb_posit_decoder_pipe.sv
// Bench for posit_decoder_pipe: 8/1 directed table plus stall/reset sequences,
// and a parallel exhaustive 16/2 sweep against a bit-serial reference decoder.
module tb_posit_decoder_pipe;
    import posit_decoder_pipe_pkg::*;

    localparam int W1 = 8;
    localparam int E1 = 1;
    localparam int W2 = 16;
    localparam int E2 = 2;
`ifdef POSIT_DEC_SCALE_EN
    localparam int OW1 = 16 + 5;
    localparam int OW2 = 27 + 7;
`else
    localparam int OW1 = 16;
    localparam int OW2 = 27;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    posit_decoder_pipe_if #(.WIDTH(W1), .ES(E1)) bus ();
    posit_decoder_pipe_if #(.WIDTH(W2), .ES(E2)) bus2 ();

    posit_decoder_pipe #(.WIDTH(W1), .ES(E1)) dut (.clk(clk), .rst(rst), .bus(bus));
    posit_decoder_pipe #(.WIDTH(W2), .ES(E2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

    int n_checks = 0;
    int n_errors = 0;
    logic [OW1-1:0] exp_q[$];
    logic [OW2-1:0] exp2_q[$];
    logic sweep_done = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- packing of expected / actual outputs ----------------
    function automatic logic [OW1-1:0] pack1(input int s, c, r, e, m, l);
        logic [OW1-1:0] v;
        v = '0;
        v[15:0] = {1'(s), 2'(c), 4'(r), 1'(e), 5'(m), 3'(l)};
`ifdef POSIT_DEC_SCALE_EN
        v[OW1-1:16] = 5'(r * (1 << E1) + e);
`endif
        return v;
    endfunction

    function automatic logic [OW2-1:0] pack2(input int s, c, r, e, m, l);
        logic [OW2-1:0] v;
        v = '0;
        v[26:0] = {1'(s), 2'(c), 5'(r), 2'(e), 13'(m), 4'(l)};
`ifdef POSIT_DEC_SCALE_EN
        v[OW2-1:27] = 7'(r * (1 << E2) + e);
`endif
        return v;
    endfunction

    logic [OW1-1:0] act1;
    logic [OW2-1:0] act2;
`ifdef POSIT_DEC_SCALE_EN
    assign act1 = {bus.out_scale, bus.out_sign, bus.out_class, bus.out_regime,
                   bus.out_exponent, bus.out_mantissa, bus.out_man_len};
    assign act2 = {bus2.out_scale, bus2.out_sign, bus2.out_class, bus2.out_regime,
                   bus2.out_exponent, bus2.out_mantissa, bus2.out_man_len};
`else
    assign act1 = {bus.out_sign, bus.out_class, bus.out_regime,
                   bus.out_exponent, bus.out_mantissa, bus.out_man_len};
    assign act2 = {bus2.out_sign, bus2.out_class, bus2.out_regime,
                   bus2.out_exponent, bus2.out_mantissa, bus2.out_man_len};
`endif

    // Reference decoder for 16/2: walks the bits one at a time.
    function automatic logic [OW2-1:0] model2(input logic [15:0] p);
        logic [15:0] a;
        logic [12:0] mv;
        logic        r0;
        int s, cls, i, k, rg, e, len;
        s = int'(p[15]);
        if (p == 16'h0000) cls = 0;
        else if (p == 16'h8000) cls = 1;
        else cls = 2;
        if (cls != 2) return pack2(s, cls, 0, 0, 0, 0);
        a  = p[15] ? (~p + 16'd1) : p;
        i  = 14;
        r0 = a[14];
        k  = 0;
        while (i >= 0 && a[i] == r0) begin
            k++;
            i--;
        end
        rg = r0 ? k - 1 : -k;
        if (i >= 0) i--;
        e = 0;
        for (int j = 0; j < E2; j++) begin
            e = e * 2;
            if (i >= 0) begin
                e += int'(a[i]);
                i--;
            end
        end
        len = i + 1;
        mv  = '0;
        for (int j = 0; j < len; j++) mv[12-j] = a[i-j];
        return pack2(s, cls, rg, e, int'(mv), len);
    endfunction

    // ---------------- directed table (8-bit, ES=1) ----------------
    typedef struct {
        logic [7:0] p;
        int s, c, r, e, m, l;
    } vec_t;
    localparam int NV = 15;
    vec_t tbl[NV];

    // ---------------- driver tasks ----------------
    task automatic send(input logic [7:0] p, input logic [OW1-1:0] e);
        int tries;
        logic done;
        tries = 0;
        done  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_posit = p;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end else begin
                tries++;
                if (tries > 50) begin
                    check("send_timeout", 64'(tries), 64'd0);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_idx(input int i);
        send(tbl[i].p, pack1(tbl[i].s, tbl[i].c, tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].l));
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_posit = '0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- scoreboard / monitor, DUT 1 ----------------
    logic [OW1-1:0] held;
    logic           held_v = 1'b0;
    logic [OW1-1:0] expv;

    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (bus.out_valid && held_v) check("stall_hold", 64'(act1), 64'(held));
            if (bus.out_valid && bus.out_ready) begin
                check("out_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    expv = exp_q.pop_front();
                    check("out_data", 64'(act1), 64'(expv));
                end
                held_v = 1'b0;
            end else if (bus.out_valid) begin
                held   = act1;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // ---------------- scoreboard / monitor, DUT 2 ----------------
    logic [OW2-1:0] expv2;
    always @(negedge clk) begin
        if (!rst2 && bus2.out_valid && bus2.out_ready) begin
            check("sweep_expected", 64'(exp2_q.size() != 0), 64'd1);
            if (exp2_q.size() != 0) begin
                expv2 = exp2_q.pop_front();
                check("sweep_out", 64'(act2), 64'(expv2));
            end
        end
    end

    // ---------------- exhaustive 16/2 sweep at full throughput ----------------
    initial begin
        int cnt, stalls, n;
        bus2.in_valid  = 1'b0;
        bus2.in_posit  = '0;
        bus2.out_ready = 1'b1;
        wait (rst2 == 1'b0);
        @(posedge clk);
        #1;
        cnt = 0;
        stalls = 0;
        while (cnt < 65536 && stalls < 100) begin
            bus2.in_valid = 1'b1;
            bus2.in_posit = cnt[15:0];
            @(negedge clk);
            if (bus2.in_ready) begin
                exp2_q.push_back(model2(cnt[15:0]));
                cnt++;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        bus2.in_valid = 1'b0;
        check("sweep_stalls", 64'(stalls), 64'd0);
        check("sweep_count", 64'(cnt), 64'd65536);
        n = 0;
        while (exp2_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("sweep_drain", 64'(exp2_q.size()), 64'd0);
        sweep_done = 1'b1;
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_500_000;
        n_errors++;
        $display("FAIL watchdog: run did not complete");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // ---------------- main directed sequence ----------------
    initial begin
        int t0, n;
        tbl[0]  = '{8'h6D, 0, 2,  1, 1, 5'b10100, 3};
        tbl[1]  = '{8'h93, 1, 2,  1, 1, 5'b10100, 3};
        tbl[2]  = '{8'h00, 0, 0,  0, 0, 0, 0};
        tbl[3]  = '{8'h80, 1, 1,  0, 0, 0, 0};
        tbl[4]  = '{8'h7F, 0, 2,  6, 0, 0, 0};
        tbl[5]  = '{8'h01, 0, 2, -6, 0, 0, 0};
        tbl[6]  = '{8'h40, 0, 2,  0, 0, 0, 4};
        tbl[7]  = '{8'h81, 1, 2,  6, 0, 0, 0};
        tbl[8]  = '{8'hFF, 1, 2, -6, 0, 0, 0};
        tbl[9]  = '{8'h55, 0, 2,  0, 1, 5'b01010, 4};
        tbl[10] = '{8'h20, 0, 2, -1, 0, 0, 4};
        tbl[11] = '{8'h3A, 0, 2, -1, 1, 5'b10100, 4};
        tbl[12] = '{8'h02, 0, 2, -5, 0, 0, 0};
        tbl[13] = '{8'h7E, 0, 2,  5, 0, 0, 0};
        tbl[14] = '{8'h7D, 0, 2,  4, 1, 0, 0};

        bus.in_valid  = 1'b0;
        bus.in_posit  = '0;
        bus.out_ready = 1'b1;
        rst  = 1'b1;
        rst2 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_data", 64'(act1), 64'(pack1(0, 0, 0, 0, 0, 0)));
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        rst  = 1'b0;
        rst2 = 1'b0;
        @(posedge clk);
        #1;

        // Latency: accepted at one edge, visible after the second.
        send_idx(0);
        idle();
        @(negedge clk);
        check("latency_s1_only", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("latency_two", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        drain("latency_drain");

        // Whole table back to back: one accept per cycle.
        t0 = cyc;
        for (int i = 0; i < NV; i++) send_idx(i);
        check("table_throughput", 64'(cyc - t0), 64'(NV));
        idle();
        drain("table_drain");

        // Back-pressure: two accepts fill the pipe, then in_ready drops.
        bus.out_ready = 1'b0;
        send_idx(9);
        send_idx(5);
        idle();
        @(negedge clk);
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk);
        #1;
        fork
            begin
                send_idx(11);
                send_idx(1);
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        drain("bp_drain");

        // Reset while both stages hold data: out_valid drops before any edge.
        bus.out_ready = 1'b0;
        send_idx(4);
        send_idx(8);
        idle();
        @(negedge clk);
        check("pre_rst_full", 64'(bus.out_valid && !bus.in_ready), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_async_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_async_data", 64'(act1), 64'(pack1(0, 0, 0, 0, 0, 0)));
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_idle", 64'(bus.out_valid), 64'd0);
        send_idx(6);
        idle();
        drain("post_rst_drain");

        n = 0;
        while (!sweep_done && n < 90000) begin
            @(posedge clk);
            n++;
        end
        check("sweep_finished", 64'(sweep_done), 64'd1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
